mux_rr_reg: RTL and testbench
=============================

MUX_RR_REG -- requirements
Module: mux_rr_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel (>=1).
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels (power of two, >=2).
REQ-003 SHALL use SEL_W = log2(CHANNELS) as the width of all channel-index fields.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  CHANNELS  per-channel valid.
REQ-008 SHALL have port in_ready  output  CHANNELS  per-channel ready.
REQ-009 SHALL have port mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 SHALL have port sel  input  SEL_W  channel index used in fixed mode.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-012 SHALL have port out_chan  output  SEL_W  index of the channel that supplied out_data.
REQ-013 SHALL have port out_valid  output  1  output register holds a word.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the word.

Function
REQ-015 SHALL implement a one-entry output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 SHALL define can_load = !out_valid || out_ready, so the register loads in the same cycle it drains.
REQ-017 In fixed mode, the grant SHALL be channel sel when in_valid[sel]=1; otherwise no grant is issued.
REQ-018 In round-robin mode, the grant SHALL go to the first channel with in_valid=1, searching upward from rr_ptr with wrap from CHANNELS-1 to 0.
REQ-019 in_ready[i] SHALL be 1 only when i is the granted channel and can_load=1; at most one in_ready bit SHALL be high per cycle.
REQ-020 An input transfer SHALL occur on a clock edge when in_valid[i] and in_ready[i] are both 1; on that edge out_data, out_chan and out_valid SHALL load (data, i, 1).
REQ-021 An output transfer (out_valid && out_ready) with no simultaneous input transfer SHALL clear out_valid on that edge.
REQ-022 Latency from input transfer to out_valid SHALL be 1 cycle; sustained throughput SHALL be 1 word per cycle when out_ready=1.
REQ-023 While FULL and out_ready=0, out_data, out_chan and out_valid SHALL hold stable regardless of in_valid, sel or mode changes.
REQ-024 rr_ptr SHALL update to (granted index + 1) mod CHANNELS on every input transfer in either mode, and SHALL be unchanged otherwise.
REQ-025 A mode or sel change SHALL affect only the grant computed in the cycle it is presented; no word already registered SHALL be altered or dropped.
REQ-026 With no valid input (or none on sel in fixed mode), all in_ready bits SHALL be 0, and out_valid SHALL fall after the pending output transfer.
REQ-027 in_ready SHALL depend combinationally on in_valid, mode, sel, rr_ptr, out_valid and out_ready only; out_* SHALL be purely registered.

Reset
REQ-028 While rst_n=0, the block SHALL asynchronously force out_valid=0, out_data=0, out_chan=0 and rr_ptr=0 (state EMPTY).
REQ-029 While rst_n=0, all in_ready bits SHALL be 0.
REQ-030 A word held at reset assertion SHALL be discarded; the first edge after deassertion SHALL behave as EMPTY with rr_ptr=0.

Verification
REQ-031 Fixed mode: mode=0, sel=2, in_valid=4'b1111, in_data ch2=0xA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0xA5, out_chan=2, out_valid=1.
REQ-032 Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 with no gaps.
REQ-033 Backpressure: FULL with out_chan=1, data 0x3C, out_ready=0 for 5 cycles while in_valid toggles and sel changes -> outputs constant, in_ready=0; out_ready=1 -> that word transfers, next granted word loads on the same edge.
REQ-034 Sparse round-robin with wrap: mode=1, rr_ptr=3, in_valid=4'b0010 -> grant 1, rr_ptr becomes 2; then in_valid=4'b0001 -> grant 0 (wrap), rr_ptr becomes 1.
REQ-035 Reset mid-operation: FULL, out_valid=1; rst_n pulsed low between edges -> out_valid=0 immediately; after release, with mode=1 and in_valid=4'b1111, the first grant is channel 0.
REQ-036 Parameter sweep: WIDTH=16, CHANNELS=8, round-robin with a random valid/ready pattern -> every accepted word appears once, in order, with the correct out_chan, and no channel is starved longer than 8 transfers.

Source files
------------

// File: rtl/mux_rr_reg.sv
// Registered N-to-1 multiplexer with fixed-select or round-robin arbitration.
// A single output register drains and refills in the same cycle, so throughput is one word per clock.
module mux_rr_reg #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_chan_q;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] cand;
  logic             grant_vld;
  logic             can_load;
  logic             load;

  // Grant: fixed channel, or first valid channel at or above rr_ptr with wrap.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    if (!mode) begin
      grant_idx = sel;
      grant_vld = in_valid[sel];
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cand = rr_ptr_q + SEL_W'(i);
        if (!grant_vld && in_valid[cand]) begin
          grant_idx = cand;
          grant_vld = 1'b1;
        end
      end
    end
  end

  assign can_load = !out_valid || out_ready;
  // rst_n gates the handshake so no input is acknowledged while reset is held.
  assign load     = grant_vld && can_load && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      out_data_q <= '0;
      out_chan_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (load) begin
        out_data_q <= in_data[grant_idx*WIDTH +: WIDTH];
        out_chan_q <= grant_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      state_d  = StFull;
      rr_ptr_d = grant_idx + SEL_W'(1);
    end else if (state_q == StFull && out_ready) begin
      state_d = StEmpty;
    end
  end

  always_comb begin
    in_ready  = '0;
    out_valid = (state_q == StFull);
    out_data  = out_data_q;
    out_chan  = out_chan_q;
    if (load) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Scoreboard bench for mux_rr_reg: a 4x8 instance for directed cases and an 8x16 instance
// for a random round-robin run; a reference model predicts grants and queues expected words.
module tb_mux_rr_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic [2:0]  sel = '0;
  logic [7:0]  in_valid = '0;
  logic        out_ready = 1'b0;
  logic [15:0] dat [8];

  logic [31:0]  in_data4;
  logic [127:0] in_data8;
  logic [3:0]   rdy4;
  logic [7:0]   od4;
  logic [1:0]   oc4;
  logic         ov4;
  logic [7:0]   rdy8;
  logic [15:0]  od8;
  logic [2:0]   oc8;
  logic         ov8;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) in_data4[i*8 +: 8] = dat[i][7:0];
    for (int i = 0; i < 8; i++) in_data8[i*16 +: 16] = dat[i];
  end

  mux_rr_reg #(.WIDTH(8), .CHANNELS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid[3:0]), .in_ready(rdy4),
    .mode(mode), .sel(sel[1:0]), .out_data(od4), .out_chan(oc4), .out_valid(ov4),
    .out_ready(out_ready)
  );

  mux_rr_reg #(.WIDTH(16), .CHANNELS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data8), .in_valid(in_valid), .in_ready(rdy8),
    .mode(mode), .sel(sel), .out_data(od8), .out_chan(oc8), .out_valid(ov8),
    .out_ready(out_ready)
  );

  typedef struct {int chan; int data;} exp_t;
  exp_t sb[$];

  int n_total = 0;
  int n_bad   = 0;
  int nch     = 4;
  int m_ptr   = 0;
  bit m_full  = 1'b0;
  int wait_cnt [8];
  int max_wait = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] obs_ready();
    return (nch == 4) ? {4'b0, rdy4} : rdy8;
  endfunction

  function automatic logic obs_valid();
    return (nch == 4) ? ov4 : ov8;
  endfunction

  // Pulse reset inside the low clock phase and check the asynchronous clear.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, obs_valid()}, 32'd0);
    check("rst_in_ready", {24'b0, obs_ready()}, 32'd0);
    check("rst_out_data", (nch == 4) ? {24'b0, od4} : {16'b0, od8}, 32'd0);
    check("rst_out_chan", (nch == 4) ? {30'b0, oc4} : {29'b0, oc8}, 32'd0);
    #1;
    rst_n  = 1'b1;
    m_full = 1'b0;
    m_ptr  = 0;
    sb.delete();
    for (int c = 0; c < 8; c++) wait_cnt[c] = 0;
  endtask

  // One clock: check outputs and in_ready against the model, then advance the model.
  task automatic step();
    int g;
    int idx;
    int mask;
    bit can;
    logic [7:0] exp_rdy;
    logic [7:0] got_rdy;
    logic [31:0] got_data;
    logic [31:0] got_chan;
    exp_t e;
    #1;
    mask     = (nch == 4) ? 32'hFF : 32'hFFFF;
    got_data = (nch == 4) ? {24'b0, od4} : {16'b0, od8};
    got_chan = (nch == 4) ? {30'b0, oc4} : {29'b0, oc8};
    got_rdy  = obs_ready();
    check("out_valid", {31'b0, obs_valid()}, {31'b0, m_full});
    if (m_full) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb[0];
        check("out_data", got_data, e.data);
        check("out_chan", got_chan, e.chan);
        if (out_ready) void'(sb.pop_front());
      end
    end
    g = -1;
    if (!mode) begin
      idx = int'(sel) % nch;
      if (in_valid[idx]) g = idx;
    end else begin
      for (int k = 0; k < nch; k++) begin
        idx = (m_ptr + k) % nch;
        if (g < 0 && in_valid[idx]) g = idx;
      end
    end
    can     = !m_full || out_ready;
    exp_rdy = '0;
    if (g >= 0 && can) exp_rdy[g] = 1'b1;
    check("in_ready", {24'b0, got_rdy}, {24'b0, exp_rdy});
    if (nch == 8 && got_rdy != 0) begin
      for (int c = 0; c < 8; c++) begin
        if (got_rdy[c] || !in_valid[c]) wait_cnt[c] = 0;
        else wait_cnt[c]++;
        if (wait_cnt[c] > max_wait) max_wait = wait_cnt[c];
      end
    end
    if (g >= 0 && can) begin
      sb.push_back('{g, int'(dat[g]) & mask});
      m_ptr  = (g + 1) % nch;
      m_full = 1'b1;
    end else if (m_full && out_ready) begin
      m_full = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int c = 0; c < 8; c++) dat[c] = 16'(c * 16'h1111);
    mode     = 1'b1;
    in_valid = 8'hFF;
    @(negedge clk);
    apply_reset();

    // Fixed select of channel 2.
    mode = 1'b0; sel = 3'd2; in_valid = 8'h0F; dat[2] = 16'h00A5; out_ready = 1'b1;
    step();
    in_valid = 8'h00;
    step();
    step();

    // Round-robin fairness from rr_ptr=0.
    apply_reset();
    mode = 1'b1; in_valid = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 4; c++) dat[c] = 16'($urandom_range(255));
      step();
    end
    in_valid = 8'h00;
    step();
    step();

    // Backpressure: hold channel 1 word 0x3C while inputs churn.
    apply_reset();
    mode = 1'b0; sel = 3'd1; in_valid = 8'h02; dat[1] = 16'h003C; out_ready = 1'b0;
    step();
    dat[1] = 16'h0077;
    for (int i = 0; i < 5; i++) begin
      in_valid = 8'($urandom_range(15));
      sel      = 3'(i);
      mode     = i[0];
      step();
    end
    mode = 1'b0; sel = 3'd3; in_valid = 8'h08; dat[3] = 16'h00C3; out_ready = 1'b1;
    step();
    in_valid = 8'h00;
    step();
    step();

    // Sparse round-robin with wrap: park rr_ptr at 3 via a channel-2 grant.
    apply_reset();
    mode = 1'b0; sel = 3'd2; in_valid = 8'h04;
    step();
    mode = 1'b1; in_valid = 8'h02;
    step();
    in_valid = 8'h01;
    step();
    in_valid = 8'h0F;
    step();
    in_valid = 8'h00;
    step();
    step();

    // Reset pulse while FULL, then first round-robin grant must be channel 0.
    mode = 1'b1; in_valid = 8'h04; out_ready = 1'b0;
    step();
    step();
    apply_reset();
    in_valid = 8'h0F; out_ready = 1'b1;
    step();
    in_valid = 8'h00;
    step();
    step();

    // Random round-robin on the 8-channel, 16-bit instance.
    nch = 8;
    apply_reset();
    mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 8; c++) dat[c] = 16'($urandom);
      in_valid  = 8'($urandom);
      out_ready = ($urandom_range(3) != 0);
      step();
    end
    in_valid = 8'h00; out_ready = 1'b1;
    step();
    step();
    check("sb_drained", sb.size(), 32'd0);
    check("no_starvation", {31'b0, (max_wait <= 8)}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
